round_seq: RTL and testbench
============================

ROUND_SEQ -- requirements
Module: round_seq

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, CLK cycles per one-second tick.
REQ-002 SHALL have parameter TIME_LIMIT, default 20, answer time per round in seconds (1..31).
REQ-003 SHALL have parameter HP_INIT, default 7, starting HP per player (1..7).
REQ-004 SHALL have parameter NUM_Q, default 16, number of questions in the database (2..16).
REQ-005 SHALL have port CLK  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port READY_1P  input  1  one-cycle pulse, local player ready.
REQ-008 SHALL have port READY_2P  input  1  level, remote player ready (asynchronous GPIO).
REQ-009 SHALL have port RESULT_1P  input  2  local answer: 00 none, 01 correct, 10 wrong, 11 ignored.
REQ-010 SHALL have port RESULT_2P  input  2  remote answer, same encoding, already synchronous.
REQ-011 SHALL have port NUM  output  4  current question index.
REQ-012 SHALL have port NUM_VALID  output  1  one-cycle pulse when NUM updates.
REQ-013 SHALL have port STATE  output  3  FSM state code.
REQ-014 SHALL have port JUDG  output  2  round verdict: 01 1P wins, 10 2P wins, 11 draw.
REQ-015 SHALL have port JUDG_VALID  output  1  one-cycle pulse qualifying JUDG.
REQ-016 SHALL have ports HP_1P, HP_2P  output  3 each  remaining HP.
REQ-017 SHALL have port SEC_LEFT  output  5  seconds left in current round.
REQ-018 SHALL have port GAME_OVER  output  1  high in OVER state.

Function
REQ-019 SHALL implement states IDLE=0, ISSUE=1, ANSWER=2, JUDGE=3, OVER=4, driven on STATE.
REQ-020 SHALL pass READY_2P through a 2-flop synchronizer before use (2-cycle latency).
REQ-021 SHALL latch a READY_1P pulse in IDLE; latch cleared on entry to ISSUE; pulses outside IDLE ignored.
REQ-022 SHALL move IDLE->ISSUE on the cycle both latched 1P-ready and synchronized 2P-ready are high.
REQ-023 ISSUE SHALL last one cycle: NUM <= (NUM+1) wrap to 0 after NUM_Q-1, NUM_VALID=1, SEC_LEFT<=TIME_LIMIT, tick counter<=0, next ANSWER.
REQ-024 In ANSWER, first cycle with any RESULT non-00/11 SHALL decide verdict: 1P correct->01; 2P correct->10; 1P wrong->10; 2P wrong->01.
REQ-025 Simultaneous same-cycle events: both correct->11; both wrong->11; correct beats wrong->correct player wins.
REQ-026 RESULT inputs SHALL be ignored outside ANSWER.
REQ-027 JUDGE SHALL last one cycle: JUDG_VALID=1, loser HP decremented, saturating at 0; draw changes no HP.
REQ-028 JUDGE SHALL go to OVER if either post-update HP is 0, else IDLE.
REQ-029 OVER SHALL hold all outputs until RST; GAME_OVER=1.
REQ-030 JUDG SHALL hold last verdict until next JUDGE.

Reset
REQ-031 On RST: STATE=IDLE, NUM=0, NUM_VALID=0, JUDG=00, JUDG_VALID=0, HP_1P=HP_2P=HP_INIT, SEC_LEFT=0, GAME_OVER=0, ready latch and synchronizer cleared.
REQ-032 RST mid-round SHALL abort the round with no HP change and no JUDG_VALID.

Configuration
REQ-033 Macro ROUND_TIMER_EN defined: tick counter counts 0..TICK_DIV-1, SEC_LEFT decrements per wrap; at SEC_LEFT 0 with no result, verdict 11 and ANSWER->JUDGE next cycle (a result on that same cycle takes precedence).
REQ-034 Macro ROUND_TIMER_EN undefined: no timer logic, SEC_LEFT constant 0, ANSWER exits only on a result.

Verification (TICK_DIV=4, TIME_LIMIT=3, HP_INIT=2, NUM_Q=3)
REQ-035 READY_1P pulse, READY_2P=1 -> ISSUE within 3 cycles, NUM 0->1, NUM_VALID single pulse.
REQ-036 ANSWER, RESULT_1P=01 -> JUDG=01, JUDG_VALID pulse, HP_2P 2->1, back to IDLE.
REQ-037 ANSWER, RESULT_1P=01 and RESULT_2P=01 same cycle -> JUDG=11, HPs unchanged.
REQ-038 Three rounds issued -> NUM 1,2,0 (wrap).
REQ-039 RESULT_2P=10 twice in separate rounds -> HP_2P=0, STATE=OVER, GAME_OVER=1, further READY ignored.
REQ-040 With ROUND_TIMER_EN, no result -> SEC_LEFT 3,2,1,0 every 4 cycles, then JUDG=11; without macro, FSM stays in ANSWER.

Source files
------------

// File: rtl/round_seq.sv
// Two-player quiz round sequencer: ready handshake, question issue, verdict and HP bookkeeping, one cycle per phase.
// No backpressure: ANSWER waits for a result (or, with ROUND_TIMER_EN defined, a countdown timeout that yields a draw).
module round_seq #(
   parameter int TICK_DIV   = 50000000,
   parameter int TIME_LIMIT = 20,
   parameter int HP_INIT    = 7,
   parameter int NUM_Q      = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       READY_1P,
   input  logic       READY_2P,
   input  logic [1:0] RESULT_1P,
   input  logic [1:0] RESULT_2P,
   output logic [3:0] NUM,
   output logic       NUM_VALID,
   output logic [2:0] STATE,
   output logic [1:0] JUDG,
   output logic       JUDG_VALID,
   output logic [2:0] HP_1P,
   output logic [2:0] HP_2P,
   output logic [4:0] SEC_LEFT,
   output logic       GAME_OVER
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      ANSWER = 3'd2,
      JUDGE  = 3'd3,
      OVER   = 3'd4
   } state_t;

   state_t     state, state_nxt;
   logic       sync_1, sync_2;
   logic       rdy_1p_lat;
   logic       issue_go;
   logic       timeout;
   logic       ok_1p, bad_1p, ok_2p, bad_2p;
   logic [1:0] verdict;

   assign ok_1p    = (RESULT_1P == 2'b01);
   assign bad_1p   = (RESULT_1P == 2'b10);
   assign ok_2p    = (RESULT_2P == 2'b01);
   assign bad_2p   = (RESULT_2P == 2'b10);
   assign issue_go = (state == IDLE) && rdy_1p_lat && sync_2;

   // A correct answer outranks a wrong one; matching events on both sides are a draw.
   always_comb begin
      verdict = 2'b00;
      if (ok_1p && ok_2p)        verdict = 2'b11;
      else if (ok_1p)            verdict = 2'b01;
      else if (ok_2p)            verdict = 2'b10;
      else if (bad_1p && bad_2p) verdict = 2'b11;
      else if (bad_1p)           verdict = 2'b10;
      else if (bad_2p)           verdict = 2'b01;
      else if (timeout)          verdict = 2'b11;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (issue_go) state_nxt = ISSUE;
         ISSUE:   state_nxt = ANSWER;
         ANSWER:  if (verdict != 2'b00) state_nxt = JUDGE;
         JUDGE:   state_nxt = (HP_1P == 3'd0 || HP_2P == 3'd0) ? OVER : IDLE;
         OVER:    state_nxt = OVER;
         default: state_nxt = IDLE;
      endcase
   end

   // NUM/JUDG/HP are registered on entry to ISSUE/JUDGE so they line up with the valid pulses.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         sync_1     <= 1'b0;
         sync_2     <= 1'b0;
         rdy_1p_lat <= 1'b0;
         NUM        <= 4'd0;
         NUM_VALID  <= 1'b0;
         JUDG       <= 2'b00;
         JUDG_VALID <= 1'b0;
         HP_1P      <= 3'(HP_INIT);
         HP_2P      <= 3'(HP_INIT);
      end else begin
         state      <= state_nxt;
         sync_1     <= READY_2P;
         sync_2     <= sync_1;
         NUM_VALID  <= 1'b0;
         JUDG_VALID <= 1'b0;
         if (issue_go) begin
            rdy_1p_lat <= 1'b0;
            NUM        <= (NUM == 4'(NUM_Q - 1)) ? 4'd0 : NUM + 4'd1;
            NUM_VALID  <= 1'b1;
         end else if (state == IDLE && READY_1P) begin
            rdy_1p_lat <= 1'b1;
         end
         if (state == ANSWER && state_nxt == JUDGE) begin
            JUDG       <= verdict;
            JUDG_VALID <= 1'b1;
            if (verdict == 2'b01 && HP_2P != 3'd0) HP_2P <= HP_2P - 3'd1;
            if (verdict == 2'b10 && HP_1P != 3'd0) HP_1P <= HP_1P - 3'd1;
         end
      end
   end

`ifdef ROUND_TIMER_EN
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   logic [TW-1:0] tick;

   always_ff @(posedge CLK) begin
      if (RST) begin
         tick     <= '0;
         SEC_LEFT <= 5'd0;
      end else if (issue_go) begin
         tick     <= '0;
         SEC_LEFT <= 5'(TIME_LIMIT);
      end else if (state == ANSWER) begin
         if (tick == TW'(TICK_DIV - 1)) begin
            tick <= '0;
            if (SEC_LEFT != 5'd0) SEC_LEFT <= SEC_LEFT - 5'd1;
         end else begin
            tick <= tick + TW'(1);
         end
      end
   end

   assign timeout = (SEC_LEFT == 5'd0);
`else
   logic unused_cfg;
   assign unused_cfg = (TICK_DIV > 0) ^ (TIME_LIMIT > 0);
   assign SEC_LEFT   = 5'd0;
   assign timeout    = 1'b0;
`endif

   assign STATE     = state;
   assign GAME_OVER = (state == OVER);
endmodule

// File: tb/tb_round_seq.sv
// Bench for round_seq: verdict vector table, hand-written multi-cycle sequences and randomized rounds vs a game-level model.
module tb_round_seq;
   localparam int TICK_DIV   = 4;
   localparam int TIME_LIMIT = 3;
   localparam int HP_INIT    = 2;
   localparam int NUM_Q      = 3;
   localparam int LIM        = TIME_LIMIT * TICK_DIV;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       READY_1P = 1'b0;
   logic       READY_2P = 1'b0;
   logic [1:0] RESULT_1P = 2'b00;
   logic [1:0] RESULT_2P = 2'b00;
   logic [3:0] NUM;
   logic       NUM_VALID;
   logic [2:0] STATE;
   logic [1:0] JUDG;
   logic       JUDG_VALID;
   logic [2:0] HP_1P, HP_2P;
   logic [4:0] SEC_LEFT;
   logic       GAME_OVER;

   round_seq #(.TICK_DIV(TICK_DIV), .TIME_LIMIT(TIME_LIMIT), .HP_INIT(HP_INIT), .NUM_Q(NUM_Q)) dut (
      .CLK(CLK), .RST(RST), .READY_1P(READY_1P), .READY_2P(READY_2P),
      .RESULT_1P(RESULT_1P), .RESULT_2P(RESULT_2P), .NUM(NUM), .NUM_VALID(NUM_VALID),
      .STATE(STATE), .JUDG(JUDG), .JUDG_VALID(JUDG_VALID), .HP_1P(HP_1P), .HP_2P(HP_2P),
      .SEC_LEFT(SEC_LEFT), .GAME_OVER(GAME_OVER)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;
   int m_num, m_hp1, m_hp2;

   typedef struct {
      logic [1:0] r1, r2, judg;
      logic [2:0] hp1, hp2;
   } vec_t;
   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // A player scores when answering correctly or when the opponent answers wrong; both scoring is a draw.
   function automatic logic [1:0] ref_verdict(input logic [1:0] r1, input logic [1:0] r2);
      logic win1, win2;
      win1 = (r1 == 2'b01) || (r2 == 2'b10);
      win2 = (r2 == 2'b01) || (r1 == 2'b10);
      return {win2, win1};
   endfunction

   task automatic reset_dut();
      RST = 1'b1;
      READY_1P = 1'b0;
      RESULT_1P = 2'b00;
      RESULT_2P = 2'b00;
      step();
      step();
      RST = 1'b0;
      m_num = 0;
      m_hp1 = HP_INIT;
      m_hp2 = HP_INIT;
   endtask

   task automatic play_round(input logic [1:0] r1, input logic [1:0] r2, input int dly, output logic [1:0] got);
      bit         seen, over;
      int         steps, k, exp_k;
      logic [1:0] exp_j;
      READY_2P = 1'b1;
      READY_1P = 1'b1;
      seen = 0;
      steps = 0;
      while (!seen && steps < 10) begin
         step();
         steps++;
         READY_1P = 1'b0;
         RESULT_1P = 2'($urandom);
         RESULT_2P = 2'($urandom);
         seen = NUM_VALID;
      end
      check("issue_seen", seen, 1);
      check("issue_latency_le3", steps <= 3, 1);
      m_num = (m_num + 1) % NUM_Q;
      check("num", NUM, m_num);
      step();
      check("num_valid_pulse", NUM_VALID, 0);
      check("answer_state", STATE, 2);
      exp_j = ref_verdict(r1, r2);
      exp_k = dly;
`ifdef ROUND_TIMER_EN
      if (dly > LIM) begin
         exp_j = 2'b11;
         exp_k = LIM;
      end
`endif
      seen = 0;
      k = 0;
      while (!seen && k < 64) begin
         if (JUDG_VALID) begin
            seen = 1;
         end else begin
`ifdef ROUND_TIMER_EN
            check("sec_left", SEC_LEFT, TIME_LIMIT - k / TICK_DIV);
`endif
            if (k == dly) begin
               RESULT_1P = r1;
               RESULT_2P = r2;
            end else begin
               RESULT_1P = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
               RESULT_2P = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
            end
            step();
            k++;
         end
      end
      RESULT_1P = 2'b00;
      RESULT_2P = 2'b00;
      check("judge_seen", seen, 1);
      check("judge_cycle", k, exp_k + 1);
      check("judg", JUDG, exp_j);
      got = JUDG;
      if (exp_j == 2'b01 && m_hp2 > 0) m_hp2--;
      if (exp_j == 2'b10 && m_hp1 > 0) m_hp1--;
      check("hp_1p", HP_1P, m_hp1);
      check("hp_2p", HP_2P, m_hp2);
      step();
      over = (m_hp1 == 0) || (m_hp2 == 0);
      check("judg_valid_pulse", JUDG_VALID, 0);
      check("judg_hold", JUDG, exp_j);
      check("post_judge_state", STATE, over ? 4 : 0);
      check("game_over", GAME_OVER, over);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [1:0] got;
      logic [1:0] r1, r2;
      vecs[0]  = '{2'b01, 2'b00, 2'b01, 3'd2, 3'd1};
      vecs[1]  = '{2'b00, 2'b01, 2'b10, 3'd1, 3'd2};
      vecs[2]  = '{2'b10, 2'b00, 2'b10, 3'd1, 3'd2};
      vecs[3]  = '{2'b00, 2'b10, 2'b01, 3'd2, 3'd1};
      vecs[4]  = '{2'b01, 2'b01, 2'b11, 3'd2, 3'd2};
      vecs[5]  = '{2'b10, 2'b10, 2'b11, 3'd2, 3'd2};
      vecs[6]  = '{2'b01, 2'b10, 2'b01, 3'd2, 3'd1};
      vecs[7]  = '{2'b10, 2'b01, 2'b10, 3'd1, 3'd2};
      vecs[8]  = '{2'b11, 2'b01, 2'b10, 3'd1, 3'd2};
      vecs[9]  = '{2'b01, 2'b11, 2'b01, 3'd2, 3'd1};
      vecs[10] = '{2'b11, 2'b10, 2'b01, 3'd2, 3'd1};

      // Reset values, sampled while RST is held.
      RST = 1'b1;
      step();
      step();
      check("rst_state", STATE, 0);
      check("rst_num", NUM, 0);
      check("rst_num_valid", NUM_VALID, 0);
      check("rst_judg", JUDG, 0);
      check("rst_judg_valid", JUDG_VALID, 0);
      check("rst_hp_1p", HP_1P, HP_INIT);
      check("rst_hp_2p", HP_2P, HP_INIT);
      check("rst_sec_left", SEC_LEFT, 0);
      check("rst_game_over", GAME_OVER, 0);

      // 2P ready passes through two flops; 1P pulse stays latched meanwhile.
      READY_2P = 1'b0;
      reset_dut();
      READY_1P = 1'b1;
      step();
      READY_1P = 1'b0;
      step();
      step();
      check("idle_wait_2p", STATE, 0);
      READY_2P = 1'b1;
      step();
      check("sync_stage1", STATE, 0);
      step();
      check("sync_stage2", STATE, 0);
      step();
      check("issue_state", STATE, 1);
      check("issue_num", NUM, 1);
      check("issue_num_valid", NUM_VALID, 1);
      m_num = 1;
      step();
      check("answer_entry", STATE, 2);
      check("num_valid_single", NUM_VALID, 0);
`ifdef ROUND_TIMER_EN
      for (int k = 0; k <= LIM; k++) begin
         check("timer_sec_left", SEC_LEFT, TIME_LIMIT - k / TICK_DIV);
         READY_1P = (k == 2);
         step();
      end
      READY_1P = 1'b0;
      check("timeout_state", STATE, 3);
      check("timeout_judg", JUDG, 2'b11);
      check("timeout_judg_valid", JUDG_VALID, 1);
      check("timeout_hp_1p", HP_1P, HP_INIT);
      check("timeout_hp_2p", HP_2P, HP_INIT);
`else
      for (int k = 0; k < 30; k++) begin
         READY_1P = (k == 2);
         step();
      end
      READY_1P = 1'b0;
      check("no_timer_hold", STATE, 2);
      check("no_timer_sec_left", SEC_LEFT, 0);
      RESULT_2P = 2'b01;
      step();
      RESULT_2P = 2'b00;
      check("late_judge_state", STATE, 3);
      check("late_judg", JUDG, 2'b10);
      check("late_judg_valid", JUDG_VALID, 1);
      check("late_hp_1p", HP_1P, HP_INIT - 1);
`endif
      step();
      check("back_to_idle", STATE, 0);
      repeat (4) step();
      check("ready_outside_idle_ignored", STATE, 0);

      // Reset in the middle of ANSWER aborts the round.
      reset_dut();
      READY_1P = 1'b1;
      step();
      READY_1P = 1'b0;
      step();
      step();
      step();
      check("pre_abort_state", STATE, 2);
      RESULT_1P = 2'b01;
      RST = 1'b1;
      step();
      RST = 1'b0;
      RESULT_1P = 2'b00;
      check("abort_state", STATE, 0);
      check("abort_judg_valid", JUDG_VALID, 0);
      check("abort_judg", JUDG, 0);
      check("abort_hp_2p", HP_2P, HP_INIT);
      check("abort_num", NUM, 0);
      step();
      check("abort_no_late_judge", JUDG_VALID, 0);
      m_num = 0;
      m_hp1 = HP_INIT;
      m_hp2 = HP_INIT;

      // Verdict table, one fresh game per vector.
      foreach (vecs[i]) begin
         reset_dut();
         play_round(vecs[i].r1, vecs[i].r2, 1, got);
         check($sformatf("vec%0d_judg", i), got, vecs[i].judg);
         check($sformatf("vec%0d_hp_1p", i), HP_1P, vecs[i].hp1);
         check($sformatf("vec%0d_hp_2p", i), HP_2P, vecs[i].hp2);
      end

      // Question index wrap, then game over and frozen outputs.
      reset_dut();
      play_round(2'b01, 2'b01, 0, got);
      play_round(2'b10, 2'b10, 2, got);
      play_round(2'b00, 2'b10, 1, got);
      check("num_wrap", NUM, 0);
      play_round(2'b00, 2'b10, 3, got);
      check("over_state", STATE, 4);
      READY_1P = 1'b1;
      step();
      READY_1P = 1'b0;
      for (int c = 0; c < 10; c++) begin
         RESULT_1P = 2'($urandom);
         RESULT_2P = 2'($urandom);
         step();
      end
      RESULT_1P = 2'b00;
      RESULT_2P = 2'b00;
      check("over_hold_state", STATE, 4);
      check("over_hold_game_over", GAME_OVER, 1);
      check("over_hold_num", NUM, 1);
      check("over_hold_num_valid", NUM_VALID, 0);
      check("over_hold_hp_1p", HP_1P, 2);
      check("over_hold_hp_2p", HP_2P, 0);
      check("over_hold_judg", JUDG, 2'b01);
      check("over_hold_judg_valid", JUDG_VALID, 0);

      // Randomized rounds against the game-level model.
      reset_dut();
      for (int n = 0; n < 40; n++) begin
         if (m_hp1 == 0 || m_hp2 == 0) reset_dut();
         do begin
            r1 = 2'($urandom);
            r2 = 2'($urandom);
         end while (ref_verdict(r1, r2) == 2'b00);
         play_round(r1, r2, $urandom_range(0, 16), got);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
